// File: rtl/svfloat_normalize.sv
// Two-stage mantissa normalizer: finds the MSB, shifts the hidden bit to out_man[MAN-1] and rebases the exponent.
// Optional sticky output (OR of right-shifted-out bits) enabled by defining SVFLOAT_NORM_STICKY_EN.

module svfloat_msb #(
  parameter int WIDTH = 48,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  output logic [IDX_W-1:0] msb
);

  // Priority scan from LSB upward so the highest set bit wins; zero input reports 0
  always_comb begin
    msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) msb = IDX_W'(i);
      else          msb = msb;
    end
  end

endmodule

module svfloat_normalize #(
  parameter int IWIDTH = 48,
  parameter int MAN    = 24,
  parameter int EXP    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] in_raw,
  input  logic [EXP-1:0]    in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAN-1:0]    out_man,
  output logic [EXP-1:0]    out_exp,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_range
`ifdef SVFLOAT_NORM_STICKY_EN
  ,
  output logic              out_sticky
`endif
);

  localparam int MSB_W = $clog2(IWIDTH);
  localparam int EW    = EXP + 2;
  localparam logic signed [EW-1:0] EMAX    = EW'((1 << (EXP - 1)) - 1);
  localparam logic signed [EW-1:0] EMIN    = ~EMAX;
  localparam logic signed [EW-1:0] MAN_TOP = EW'(MAN - 1);

  logic              s1_valid_r;
  logic [IWIDTH-1:0] s1_raw_r;
  logic [EXP-1:0]    s1_exp_r;
  logic              s1_sign_r;
  logic [MSB_W-1:0]  s1_msb_r;
  logic              s1_zero_r;
  logic              s2_valid_r;

  logic [MSB_W-1:0]     msb_s;
  logic                 s1_adv_s;
  logic                 s2_adv_s;
  logic signed [EW-1:0] d_s;
  logic signed [EW-1:0] e_s;
  logic [EW-1:0]        shamt_s;
  logic [MAN-1:0]       man_s;
  logic [EXP-1:0]       exp_s;
  logic                 range_s;
  logic                 sticky_s;

  svfloat_msb #(.WIDTH(IWIDTH), .IDX_W(MSB_W)) u_msb (
    .value (in_raw),
    .msb   (msb_s)
  );

  assign s2_adv_s  = !s2_valid_r || out_ready;
  assign s1_adv_s  = !s1_valid_r || s2_adv_s;
  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_r;

  // Stage 1 capture: raw operand plus its MSB position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_raw_r   <= '0;
      s1_exp_r   <= '0;
      s1_sign_r  <= 1'b0;
      s1_msb_r   <= '0;
      s1_zero_r  <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_raw_r  <= in_raw;
        s1_exp_r  <= in_exp;
        s1_sign_r <= in_sign;
        s1_msb_r  <= msb_s;
        s1_zero_r <= (in_raw == {IWIDTH{1'b0}});
      end
    end
  end

  // Stage 2 datapath: shift toward MAN-1 and saturate the rebased exponent
  always_comb begin
    d_s = $signed(EW'(s1_msb_r)) - MAN_TOP;
    e_s = $signed({{2{s1_exp_r[EXP-1]}}, s1_exp_r}) + d_s;
    if (!d_s[EW-1]) begin
      shamt_s = $unsigned(d_s);
      man_s   = MAN'(s1_raw_r >> shamt_s);
    end else begin
      shamt_s = $unsigned(-d_s);
      man_s   = MAN'(s1_raw_r << shamt_s);
    end
    if (e_s > EMAX) begin
      exp_s   = EMAX[EXP-1:0];
      range_s = 1'b1;
    end else if (e_s < EMIN) begin
      exp_s   = EMIN[EXP-1:0];
      range_s = 1'b1;
    end else begin
      exp_s   = e_s[EXP-1:0];
      range_s = 1'b0;
    end
  end

`ifdef SVFLOAT_NORM_STICKY_EN
  // Sticky collects every bit dropped by a right shift
  always_comb begin
    if (!d_s[EW-1] && !s1_zero_r) sticky_s = |(s1_raw_r & ~({IWIDTH{1'b1}} << shamt_s));
    else                          sticky_s = 1'b0;
  end
`else
  assign sticky_s = 1'b0;
`endif

  // Stage 2 output registers, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      out_man    <= '0;
      out_exp    <= '0;
      out_sign   <= 1'b0;
      out_zero   <= 1'b0;
      out_range  <= 1'b0;
`ifdef SVFLOAT_NORM_STICKY_EN
      out_sticky <= 1'b0;
`endif
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_sign <= s1_sign_r;
        out_zero <= s1_zero_r;
        // A zero operand has no MSB, so its shift/exponent results are discarded
        out_man   <= s1_zero_r ? {MAN{1'b0}} : man_s;
        out_exp   <= s1_zero_r ? {EXP{1'b0}} : exp_s;
        out_range <= s1_zero_r ? 1'b0 : range_s;
`ifdef SVFLOAT_NORM_STICKY_EN
        out_sticky <= sticky_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_svfloat_normalize.sv
// Self-checking bench for svfloat_normalize: directed vectors, backpressure, reset and a randomized scoreboard run.
// Build with SVFLOAT_NORM_STICKY_EN defined to also check out_sticky.

module tb_svfloat_normalize;

  localparam int IWIDTH = 48;
  localparam int MAN    = 24;
  localparam int EXP    = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [IWIDTH-1:0] in_raw;
  logic [EXP-1:0]    in_exp;
  logic              in_sign;
  logic              out_valid;
  logic              out_ready;
  logic [MAN-1:0]    out_man;
  logic [EXP-1:0]    out_exp;
  logic              out_sign;
  logic              out_zero;
  logic              out_range;
`ifdef SVFLOAT_NORM_STICKY_EN
  logic              out_sticky;
`endif

  typedef struct packed {
    logic [MAN-1:0] man;
    logic [EXP-1:0] exp;
    logic           sign;
    logic           zero;
    logic           range;
    logic           sticky;
  } res_t;

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;
  logic hold_v = 1'b0;
  res_t hold_r;

  svfloat_normalize #(.IWIDTH(IWIDTH), .MAN(MAN), .EXP(EXP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_raw    (in_raw),
    .in_exp    (in_exp),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_man   (out_man),
    .out_exp   (out_exp),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_range (out_range)
`ifdef SVFLOAT_NORM_STICKY_EN
    ,
    .out_sticky(out_sticky)
`endif
  );

  always #5 clk = ~clk;

  // Reference: renormalize by repeated halving/doubling, then clamp the exponent
  function automatic res_t model(input logic [IWIDTH-1:0] raw, input logic [EXP-1:0] ex, input logic sg);
    res_t r;
    longint unsigned m;
    longint e;
    longint lim;
    r = '0;
    r.sign = sg;
    if (raw == '0) begin
      r.zero = 1'b1;
      return r;
    end
    m = 64'(raw);
    e = longint'($signed(ex));
    while (m >= (64'd1 << MAN)) begin
      r.sticky = r.sticky | m[0];
      m = m >> 1;
      e++;
    end
    while (m < (64'd1 << (MAN - 1))) begin
      m = m << 1;
      e--;
    end
    r.man = MAN'(m);
    lim = longint'(1) << (EXP - 1);
    if (e > lim - 1) begin
      r.exp = EXP'(lim - 1);
      r.range = 1'b1;
    end else if (e < -lim) begin
      r.exp = EXP'(-lim);
      r.range = 1'b1;
    end else begin
      r.exp = EXP'(e);
    end
    return r;
  endfunction

  // Scoreboard monitor: checks order, values and stability under stall
  always @(negedge clk) begin
    res_t act;
    res_t ex;
    act = {out_man, out_exp, out_sign, out_zero, out_range, 1'b0};
`ifdef SVFLOAT_NORM_STICKY_EN
    act.sticky = out_sticky;
`endif
    if (!rst_n) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!out_valid || act !== hold_r) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b data=%h, need valid=1 data=%h", out_valid, act, hold_r);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        n_out++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%h, need no beat", act);
        end else begin
          ex = sb.pop_front();
`ifndef SVFLOAT_NORM_STICKY_EN
          ex.sticky = 1'b0;
`endif
          if (act !== ex) begin
            errors++;
            $display("FAIL scoreboard: got %h (exp=%0d), need %h (exp=%0d)", act, $signed(act.exp), ex, $signed(ex.exp));
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_r = act;
      if (in_valid && in_ready) sb.push_back(model(in_raw, in_exp, in_sign));
    end
  end

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_man, out_exp, out_sign, out_zero, out_range} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b man=%h exp=%h s=%0b z=%0b r=%0b, need all 0",
               out_valid, out_man, out_exp, out_sign, out_zero, out_range);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, need 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_directed();
    res_t vec_exp [6];
    logic [IWIDTH-1:0] vec_raw [6];
    logic [EXP-1:0] vec_e [6];
    logic vec_s [6];
    vec_raw[0] = 48'h1;            vec_e[0] = 10'd0;   vec_s[0] = 1'b1;
    vec_exp[0] = {24'h800000, 10'h3E9, 1'b1, 1'b0, 1'b0, 1'b0};
    vec_raw[1] = 48'h800000000001; vec_e[1] = 10'd5;   vec_s[1] = 1'b0;
    vec_exp[1] = {24'h800000, 10'd29, 1'b0, 1'b0, 1'b0, 1'b1};
    vec_raw[2] = 48'h800000000000; vec_e[2] = 10'd5;   vec_s[2] = 1'b0;
    vec_exp[2] = {24'h800000, 10'd29, 1'b0, 1'b0, 1'b0, 1'b0};
    vec_raw[3] = 48'h0;            vec_e[3] = 10'd100; vec_s[3] = 1'b1;
    vec_exp[3] = {24'h000000, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vec_raw[4] = 48'h800000000000; vec_e[4] = 10'd500; vec_s[4] = 1'b0;
    vec_exp[4] = {24'h800000, 10'd511, 1'b0, 1'b0, 1'b1, 1'b0};
    vec_raw[5] = 48'h1;            vec_e[5] = 10'h200; vec_s[5] = 1'b0;
    vec_exp[5] = {24'h800000, 10'h200, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_raw    = vec_raw[i];
      in_exp    = vec_e[i];
      in_sign   = vec_s[i];
      @(posedge clk);
      #1 in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early[%0d]: got out_valid=%0b, need 0", i, out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_man, out_exp, out_sign, out_zero, out_range} !==
          {1'b1, vec_exp[i].man, vec_exp[i].exp, vec_exp[i].sign, vec_exp[i].zero, vec_exp[i].range}) begin
        errors++;
        $display("FAIL directed[%0d]: got v=%0b man=%h exp=%0d s=%0b z=%0b r=%0b, need v=1 man=%h exp=%0d s=%0b z=%0b r=%0b",
                 i, out_valid, out_man, $signed(out_exp), out_sign, out_zero, out_range,
                 vec_exp[i].man, $signed(vec_exp[i].exp), vec_exp[i].sign, vec_exp[i].zero, vec_exp[i].range);
      end
`ifdef SVFLOAT_NORM_STICKY_EN
      checks++;
      if (out_sticky !== vec_exp[i].sticky) begin
        errors++;
        $display("FAIL sticky[%0d]: got %0b, need %0b", i, out_sticky, vec_exp[i].sticky);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int base;
    @(posedge clk);
    #1;
    base = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_raw   = IWIDTH'({$urandom, $urandom} >> $urandom_range(0, 63));
      in_exp   = EXP'($urandom);
      in_sign  = 1'($urandom);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready[%0d]: got %0b, need 1", i, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n_out - base != 20) begin
      errors++;
      $display("FAIL b2b_count: got %0d outputs, need 20", n_out - base);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int base;
    int rel;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    idx  = 0;
    base = n_out;
    in_exp  = '0;
    in_sign = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 5);
      in_raw   = IWIDTH'(idx + 1);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: got accepted=%0d in_ready=%0b out_valid=%0b, need 2 0 1", idx, in_ready, out_valid);
    end
    out_ready = 1'b1;
    rel = 0;
    while (n_out - base < 5 && rel < 12) begin
      in_valid = (idx < 5);
      in_raw   = IWIDTH'(idx + 1);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      rel++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (n_out - base != 5 || rel != 5) begin
      errors++;
      $display("FAIL bp_release: got %0d outputs in %0d cycles, need 5 in 5", n_out - base, rel);
    end
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_raw    = ($urandom_range(0, 19) == 0) ? '0 : IWIDTH'({$urandom, $urandom} >> $urandom_range(0, 63));
      in_exp    = EXP'($urandom);
      in_sign   = 1'($urandom);
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got %0d beats pending, need 0", sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_raw    = 48'h7;
    in_exp    = 10'd3;
    in_sign   = 1'b0;
    @(posedge clk);
    #1 in_raw = 48'h9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_full: got out_valid=%0b in_ready=%0b, need 1 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: got out_valid=%0b, need 0", out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale[%0d]: got out_valid=%0b, need 0", i, out_valid);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_raw   = 48'h10;
    in_exp   = 10'd0;
    in_sign  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_man !== 24'h800000 || out_exp !== 10'h3ED || out_sign !== 1'b1) begin
      errors++;
      $display("FAIL mid_post_reset: got v=%0b man=%h exp=%0d s=%0b, need v=1 man=800000 exp=-19 s=1",
               out_valid, out_man, $signed(out_exp), out_sign);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_raw    = '0;
    in_exp    = '0;
    in_sign   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/svfloat_normalize.md
Name: svfloat_normalize

Overview:
- Pipelined normalizer that sits directly downstream of the MSB finder. Takes an unnormalized integer mantissa plus an exponent, locates the MSB, and shifts the mantissa so that the hidden bit lands at out_man[MAN-1]. Adjusts the exponent to match.
- Feeds rounding/packing stages after integer-to-float conversion, multiply and add.
- Valid/ready handshake on both sides, 2-cycle latency, 1 result per cycle throughput.

Parameters:
- IWIDTH, 48, width of input raw mantissa.
- MAN, 24, width of output mantissa including hidden bit; MAN <= IWIDTH.
- EXP, 10, width of signed exponent (two's complement) on input and output.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input transfer request.
- in_ready  output  1  stage can accept input.
- in_raw  input  IWIDTH  unnormalized mantissa; value = in_raw * 2^in_exp.
- in_exp  input  EXP  signed exponent of in_raw LSB.
- in_sign  input  1  sign, passed through.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_man  output  MAN  normalized mantissa; value ~= out_man * 2^out_exp.
- out_exp  output  EXP  signed exponent of out_man LSB.
- out_sign  output  1  sign, delayed copy of in_sign.
- out_zero  output  1  in_raw was zero.
- out_range  output  1  exponent saturated.

Behaviour:
- Reset (async assert, sync-safe deassert): s1_valid, s2_valid, out_valid = 0. All data registers (out_man, out_exp, out_sign, out_zero, out_range, sticky) = 0.
- Stage 1 (S1):
  - msb = index of highest set bit of in_raw, via an instance of svfloat_msb, width IWIDTH.
  - On in_valid && in_ready, S1 registers raw, exp, sign, msb and zero = (in_raw == 0).
- Stage 2 (S2), from S1 registers:
  - Shift amount d = msb - (MAN-1), computed signed.
  - d >= 0: out_man = raw >> d, truncating.
  - d < 0: out_man = raw << -d.
  - Exponent: e = exp + d, computed in EXP+2 bits.
  - e > 2^(EXP-1)-1: out_exp = 2^(EXP-1)-1, out_range = 1.
  - e < -2^(EXP-1): out_exp = -2^(EXP-1), out_range = 1.
  - Otherwise out_exp = e, out_range = 0.
  - Mantissa is not altered on saturation.
- Zero input: out_man = 0, out_exp = 0, out_zero = 1, out_range = 0, out_sign passed through.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, with no combinational path from in_valid.
  - out_valid = s2_valid. Output data is held stable while out_valid && !out_ready.
- Latency: a beat accepted in cycle N appears with out_valid in cycle N+2 when unstalled.
- Ordering is preserved. No beat is dropped or duplicated under any out_ready pattern. Holds 2 beats maximum.
- Simultaneous: with both stages full and out_ready = 1, the S2 output, the S1->S2 move and a new input all occur in the same cycle.
- Reset mid-operation: in-flight beats are discarded and out_valid drops immediately on assertion.

Optional Feature:
- Macro: SVFLOAT_NORM_STICKY_EN.
- Defined:
  - Adds output port out_sticky (1 bit), the OR of all bits shifted out of raw when d > 0. It is 0 when d <= 0 or on zero input.
  - out_sticky is registered with S2 and reset to 0.
- Undefined: the port and its logic are absent; shifted-out bits are silently truncated.

Test Plan:
- Basic latency: in_raw=1, in_exp=0, in_sign=1, defaults, out_ready=1 -> 2 cycles later out_man=0x800000, out_exp=-23, out_sign=1, out_zero=0, out_range=0.
- Right shift with sticky: in_raw=2^47+1, in_exp=5 -> out_man=0x800000, out_exp=29, out_sticky=1 (with macro). With in_raw=2^47, out_sticky=0.
- Zero input: in_raw=0, in_exp=100 -> out_zero=1, out_man=0, out_exp=0, out_range=0.
- Saturation:
  - in_raw=2^47, in_exp=500 -> out_exp=511, out_range=1, out_man=0x800000.
  - in_raw=1, in_exp=-512 -> out_exp=-512, out_range=1.
- Backpressure: stream 5 beats (raw=1..5, exp=0) with out_ready=0 for 6 cycles, then 1 -> in_ready=0 after 2 accepted. All 5 results emerge in order with held-stable data. Full throughput is reached after release.
- Reset mid-stream: assert rst_n=0 with both stages valid -> out_valid=0 at once, no stale beat after release. First post-reset input appears after 2 cycles.
